qram_ddr_reader: RTL and testbench



---
 rtl/qram_ddr_reader.sv | 169 ++++++++++++++++
 tb/tb_qram_ddr_reader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/qram_ddr_reader.sv
// Read-side initiator for the QRAM serial DDR link: shifts a request address out, deserializes the read word.
// Optional even-parity slot on the read data is enabled by defining QRAM_READ_PARITY_EN.
module qram_ddr_reader #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 2
) (
  input  logic              Crystal50Mhz1,
  input  logic              Reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [ADDR_W-1:0] ReqAddr,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [DATA_W-1:0] RspData,
  output logic              RspError,
  output logic              QRAM_DDRClockP,
  output logic              QRAM_DDRClockN,
  output logic              AddressQBit,
  output logic              WrtingToQBit,
  input  logic              QBitToRead
);

`ifdef QRAM_READ_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int DW_EXT = DATA_W + PAR_W;
  localparam int MAX_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int BIT_W  = $clog2(MAX_W + 1);
  localparam int SLOT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_TURN, S_DATA, S_RESP} state_t;

  state_t              r_state, w_state_nxt;
  logic [SLOT_W-1:0]   r_slot, w_slot_nxt;
  logic [BIT_W-1:0]    r_bit, w_bit_nxt;
  logic [ADDR_W-1:0]   r_addr_sh, w_addr_sh_nxt;
  logic [DW_EXT-1:0]   r_data_sh, w_data_sh_nxt;
  logic                r_clk_p, w_clk_p_nxt;
  logic                r_addr_bit, w_addr_bit_nxt;
  logic [DATA_W-1:0]   r_rsp_data, w_rsp_data_nxt;
  logic                w_slot_end;
  logic [DW_EXT-1:0]   w_word;
`ifdef QRAM_READ_PARITY_EN
  logic                r_rsp_err, w_rsp_err_nxt;
`endif

  always_ff @(posedge Crystal50Mhz1 or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_slot     <= '0;
      r_bit      <= '0;
      r_addr_sh  <= '0;
      r_data_sh  <= '0;
      r_clk_p    <= 1'b0;
      r_addr_bit <= 1'b0;
      r_rsp_data <= '0;
`ifdef QRAM_READ_PARITY_EN
      r_rsp_err  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_slot     <= w_slot_nxt;
      r_bit      <= w_bit_nxt;
      r_addr_sh  <= w_addr_sh_nxt;
      r_data_sh  <= w_data_sh_nxt;
      r_clk_p    <= w_clk_p_nxt;
      r_addr_bit <= w_addr_bit_nxt;
      r_rsp_data <= w_rsp_data_nxt;
`ifdef QRAM_READ_PARITY_EN
      r_rsp_err  <= w_rsp_err_nxt;
`endif
    end
  end

  // All registered outputs change on the edge that starts a slot, so slot
  // boundaries are decided one cycle early, on the last cycle of the prior slot.
  always_comb begin
    w_state_nxt    = r_state;
    w_slot_nxt     = r_slot;
    w_bit_nxt      = r_bit;
    w_addr_sh_nxt  = r_addr_sh;
    w_data_sh_nxt  = r_data_sh;
    w_clk_p_nxt    = r_clk_p;
    w_addr_bit_nxt = r_addr_bit;
    w_rsp_data_nxt = r_rsp_data;
`ifdef QRAM_READ_PARITY_EN
    w_rsp_err_nxt  = r_rsp_err;
`endif
    w_slot_end = (r_slot == SLOT_LAST);
    w_word     = DW_EXT'({r_data_sh, QBitToRead});

    if (r_state == S_ADDR || r_state == S_TURN || r_state == S_DATA)
      w_slot_nxt = w_slot_end ? '0 : r_slot + 1'b1;

    case (r_state)
      S_IDLE: begin
        if (ReqValid) begin
          w_state_nxt    = S_ADDR;
          w_slot_nxt     = '0;
          w_bit_nxt      = BIT_W'(ADDR_W - 1);
          w_clk_p_nxt    = 1'b1;
          w_addr_bit_nxt = ReqAddr[ADDR_W-1];
          w_addr_sh_nxt  = ReqAddr << 1;
          w_data_sh_nxt  = '0;
        end
      end
      S_ADDR: begin
        if (w_slot_end) begin
          w_clk_p_nxt = ~r_clk_p;
          if (r_bit == '0) begin
            w_state_nxt    = S_TURN;
            w_bit_nxt      = '0;
            w_addr_bit_nxt = 1'b0;
          end else begin
            w_bit_nxt      = r_bit - 1'b1;
            w_addr_bit_nxt = r_addr_sh[ADDR_W-1];
            w_addr_sh_nxt  = r_addr_sh << 1;
          end
        end
      end
      S_TURN: begin
        if (w_slot_end) begin
          w_clk_p_nxt = ~r_clk_p;
          w_state_nxt = S_DATA;
          w_bit_nxt   = BIT_W'(DW_EXT - 1);
        end
      end
      S_DATA: begin
        if (w_slot_end) begin
          w_data_sh_nxt = w_word;
          if (r_bit == '0) begin
            w_state_nxt    = S_RESP;
            w_clk_p_nxt    = 1'b0;
            w_rsp_data_nxt = w_word[DW_EXT-1 -: DATA_W];
`ifdef QRAM_READ_PARITY_EN
            w_rsp_err_nxt  = ^w_word;
`endif
          end else begin
            w_clk_p_nxt = ~r_clk_p;
            w_bit_nxt   = r_bit - 1'b1;
          end
        end
      end
      S_RESP: begin
        if (RspReady)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign ReqReady       = (r_state == S_IDLE);
  assign RspValid       = (r_state == S_RESP);
  assign RspData        = r_rsp_data;
  assign QRAM_DDRClockP = r_clk_p;
  assign QRAM_DDRClockN = ~r_clk_p;
  assign AddressQBit    = r_addr_bit;
  assign WrtingToQBit   = 1'b0;
`ifdef QRAM_READ_PARITY_EN
  assign RspError       = r_rsp_err;
`else
  assign RspError       = 1'b0;
`endif

endmodule

// File: tb/tb_qram_ddr_reader.sv
// Directed bench for qram_ddr_reader: default-parameter instance plus a CLK_DIV=1, 4-bit instance.
module tb_qram_ddr_reader;
`ifdef QRAM_READ_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int DIV   = 2;
  localparam int DX    = DW + PAR;
  localparam int MDX   = 4 + PAR;
  localparam int LAT   = 1 + (AW + 1 + DW + PAR) * DIV;
  localparam int LAT_M = 1 + (4 + 1 + 4 + PAR);

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0, rsp_error;
  logic          clk_p, clk_n, addr_bit, wr, qbit = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] rsp_data;

  logic          m_valid = 1'b0, m_ready, m_rsp_valid, m_rsp_ready = 1'b0, m_rsp_error;
  logic          m_clk_p, m_clk_n, m_addr_bit, m_wr, m_qbit = 1'b0;
  logic [3:0]    m_addr = '0;
  logic [3:0]    m_rsp_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  qram_ddr_reader #(.ADDR_W(AW), .DATA_W(DW), .CLK_DIV(DIV)) u_dut (
    .Crystal50Mhz1(clk), .Reset(rst),
    .ReqValid(req_valid), .ReqReady(req_ready), .ReqAddr(req_addr),
    .RspValid(rsp_valid), .RspReady(rsp_ready), .RspData(rsp_data), .RspError(rsp_error),
    .QRAM_DDRClockP(clk_p), .QRAM_DDRClockN(clk_n), .AddressQBit(addr_bit),
    .WrtingToQBit(wr), .QBitToRead(qbit)
  );

  qram_ddr_reader #(.ADDR_W(4), .DATA_W(4), .CLK_DIV(1)) u_min (
    .Crystal50Mhz1(clk), .Reset(rst),
    .ReqValid(m_valid), .ReqReady(m_ready), .ReqAddr(m_addr),
    .RspValid(m_rsp_valid), .RspReady(m_rsp_ready), .RspData(m_rsp_data), .RspError(m_rsp_error),
    .QRAM_DDRClockP(m_clk_p), .QRAM_DDRClockN(m_clk_n), .AddressQBit(m_addr_bit),
    .WrtingToQBit(m_wr), .QBitToRead(m_qbit)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"},  rsp_data, 0);
    chk({tag, "_rsp_error"}, rsp_error, 0);
    chk({tag, "_clk_p"},     clk_p, 0);
    chk({tag, "_clk_n"},     clk_n, 1);
    chk({tag, "_addr_bit"},  addr_bit, 0);
    chk({tag, "_wr"},        wr, 0);
  endtask

  // One read on the default instance; abort_k>0 asserts reset in that cycle after acceptance.
  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic pb,
                         input int abort_k, input int hold);
    logic [DX-1:0] dext;
    logic          exp_err, prev_p, n_ok, gap_ok, busy_ok, bp_ok, no_rsp;
    int            k, s, toggles, last_t;
    dext    = DX'({d, pb} >> (1 - PAR));
    exp_err = (PAR == 1) ? ^{d, pb} : 1'b0;
    req_addr  = a;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    k = 1; toggles = 0; last_t = 0; prev_p = 1'b0;
    n_ok = 1'b1; gap_ok = 1'b1; busy_ok = 1'b1;
    while (!rsp_valid && k <= LAT + 5) begin
      s = (k - 1) / DIV;
      if (clk_n !== ~clk_p) n_ok = 1'b0;
      if (req_ready !== 1'b0) busy_ok = 1'b0;
      if (clk_p !== prev_p) begin
        toggles++;
        if (toggles > 1 && (k - last_t) != DIV) gap_ok = 1'b0;
        last_t = k;
      end
      prev_p = clk_p;
      if ((k - 1) % DIV == 0 && s < AW) chk("addr_bit", addr_bit, a[AW-1-s]);
      if ((k - 1) % DIV == 0 && s == AW) chk("turn_addr_zero", addr_bit, 0);
      qbit = (s >= AW + 1 && s - (AW + 1) < DX) ? dext[DX-1-(s-AW-1)] : 1'b1;
      if (k == abort_k) begin
        #2 rst = 1'b1;
        #1 reset_checks("midreset");
        tick();
        rst = 1'b0;
        no_rsp = 1'b1;
        for (int i = 0; i < LAT + 5; i++) begin
          if (rsp_valid !== 1'b0) no_rsp = 1'b0;
          tick();
        end
        chk("no_rsp_after_reset", no_rsp, 1);
        chk("ready_after_reset", req_ready, 1);
        return;
      end
      tick();
      k++;
    end
    chk("rsp_latency", k, LAT);
    chk("rsp_data", rsp_data, d);
    chk("rsp_error", rsp_error, exp_err);
    chk("clk_n_complement", n_ok, 1);
    chk("clk_p_toggles", toggles, AW + 1 + DW + PAR);
    chk("clk_p_spacing", gap_ok, 1);
    chk("busy_not_ready", busy_ok, 1);
    chk("resp_clk_p_low", clk_p, 0);
    bp_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_data !== d || rsp_error !== exp_err || req_ready !== 1'b0
          || clk_p !== 1'b0)
        bp_ok = 1'b0;
    end
    chk("backpressure_stable", bp_ok, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("idle_req_ready", req_ready, 1);
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("idle_clk_p", clk_p, 0);
  endtask

  task automatic m_read(input logic [3:0] a, input logic [3:0] d, input logic pb);
    logic [MDX-1:0] dext;
    logic           exp_err;
    int             k, s;
    dext    = MDX'({d, pb} >> (1 - PAR));
    exp_err = (PAR == 1) ? ^{d, pb} : 1'b0;
    m_addr  = a;
    m_valid = 1'b1;
    tick();
    m_valid = 1'b0;
    k = 1;
    while (!m_rsp_valid && k <= LAT_M + 5) begin
      s = k - 1;
      if (s < 4) chk("m_addr_bit", m_addr_bit, a[3-s]);
      m_qbit = (s >= 5 && s - 5 < MDX) ? dext[MDX-1-(s-5)] : 1'b1;
      tick();
      k++;
    end
    chk("m_rsp_latency", k, LAT_M);
    chk("m_rsp_data", m_rsp_data, d);
    chk("m_rsp_error", m_rsp_error, exp_err);
    m_rsp_ready = 1'b1;
    tick();
    m_rsp_ready = 1'b0;
    chk("m_idle_ready", m_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    reset_checks("reset");
    chk("m_reset_ready", m_ready, 1);
    chk("m_reset_clk_p", m_clk_p, 0);
    rst = 1'b0;
    tick();

    do_read(8'hA5, 16'h3C96, ^16'h3C96, 0, 20);
    do_read(8'h5A, 16'hFFFF, 1'b0, 1 + (AW + 1 + 5) * DIV, 0);
    do_read(8'h3C, 16'h8001, 1'b0, 0, 0);
    do_read(8'hFF, 16'h0000, 1'b0, 0, 0);
    do_read(8'h00, 16'hFFFF, 1'b0, 0, 1);
    m_read(4'h9, 4'h6, 1'b0);
`ifdef QRAM_READ_PARITY_EN
    do_read(8'h12, 16'h0001, 1'b1, 0, 0);
    do_read(8'h12, 16'h0001, 1'b0, 0, 0);
    m_read(4'h7, 4'h1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
